// File: rtl/kgp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// kgp_ctrl_pkg
//   Shared definitions for the KGPRISC multi-cycle control unit:
//   opcode values, FSM state encoding and ALU-op class encodings.
// -----------------------------------------------------------------------------
package kgp_ctrl_pkg;

  // Opcode field values (6-bit opcode in the top bits of the instruction).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000100;
  localparam logic [5:0] OP_COMPI = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_CALL  = 6'b000110;
  localparam logic [5:0] OP_RET   = 6'b000111;
  // Conditional/unconditional branches occupy a contiguous range.
  localparam logic [5:0] OP_BR_LO = 6'b010000;
  localparam logic [5:0] OP_BR_HI = 6'b011001;

  // ALU operation classes seen by the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // address add (lw/sw)
  localparam logic [1:0] ALUOP_FUNCT = 2'b01;  // R-type, decoded from funct
  localparam logic [1:0] ALUOP_IMM   = 2'b10;  // immediate operation

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

endpackage : kgp_ctrl_pkg

// File: rtl/kgp_opcode_class.sv
// -----------------------------------------------------------------------------
// kgp_opcode_class
//   Purely combinational opcode classifier. Exactly one of the is_* outputs
//   is high for any opcode; is_illegal_o covers everything not recognised.
//
// Ports
//   opcode_i      [OPCODE_W]  latched opcode
//   is_rtype_o                R-type ALU instruction
//   is_imm_o                  addi / compi
//   is_load_o                 lw
//   is_store_o                sw
//   is_branch_o               branch range OP_BR_LO..OP_BR_HI
//   is_call_o                 call
//   is_ret_o                  ret
//   is_illegal_o              none of the above
// -----------------------------------------------------------------------------
module kgp_opcode_class
  import kgp_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                is_rtype_o,
  output logic                is_imm_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                is_branch_o,
  output logic                is_call_o,
  output logic                is_ret_o,
  output logic                is_illegal_o
);

  // Size the package constants to the opcode field once, so every compare
  // below is width-matched.
  localparam logic [OPCODE_W-1:0] C_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] C_ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] C_COMPI = OPCODE_W'(OP_COMPI);
  localparam logic [OPCODE_W-1:0] C_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] C_SW    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] C_CALL  = OPCODE_W'(OP_CALL);
  localparam logic [OPCODE_W-1:0] C_RET   = OPCODE_W'(OP_RET);
  localparam logic [OPCODE_W-1:0] C_BR_LO = OPCODE_W'(OP_BR_LO);
  localparam logic [OPCODE_W-1:0] C_BR_HI = OPCODE_W'(OP_BR_HI);

  assign is_rtype_o  = (opcode_i == C_RTYPE);
  assign is_imm_o    = (opcode_i == C_ADDI) || (opcode_i == C_COMPI);
  assign is_load_o   = (opcode_i == C_LW);
  assign is_store_o  = (opcode_i == C_SW);
  assign is_branch_o = (opcode_i >= C_BR_LO) && (opcode_i <= C_BR_HI);
  assign is_call_o   = (opcode_i == C_CALL);
  assign is_ret_o    = (opcode_i == C_RET);

  assign is_illegal_o = ~(is_rtype_o | is_imm_o | is_load_o | is_store_o |
                          is_branch_o | is_call_o | is_ret_o);

endmodule : kgp_opcode_class

// File: rtl/kgp_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// kgp_multicycle_ctrl
//   Multi-cycle control unit for KGPRISC. A Moore FSM sequences each
//   instruction through FETCH, DECODE, EXEC, (MEM), (WB). Data-memory
//   accesses wait for mem_ready with a bounded timeout; unknown opcodes and
//   timeouts park the block in TRAP with a sticky flag until reset.
//   All outputs decode from the registered state and latched opcode only.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        run enable, honoured at instruction boundaries
//   instr        instruction-memory output, sampled in FETCH
//   mem_ready    data-memory completion, sampled in MEM
//   ir_write     load instruction register (FETCH)
//   pc_write     PC update (FETCH: PC+4, EXEC: branch target)
//   Branch       select branch/call/ret target in EXEC
//   MemRead      data-memory read request (lw, MEM)
//   MemWrite     data-memory write request (sw, MEM)
//   MemtoReg     write-back data comes from memory (lw, WB)
//   ALUop        ALU operation class
//   ALUsrc       ALU B operand is the immediate
//   RegWrite     register-file write enable (WB)
//   ra_RegWrite  return-address register write (call, EXEC)
//   busy         high outside IDLE and TRAP
//   illegal_op   sticky: unknown opcode trapped
//   mem_timeout  sticky: mem_ready not seen within MEM_TMO cycles
//   state_o      current FSM state, for debug
// -----------------------------------------------------------------------------
module kgp_multicycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int MEM_TMO  = 15   // 1..255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               Branch,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               ALUsrc,
  output logic               RegWrite,
  output logic               ra_RegWrite,
  output logic               busy,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [2:0]         state_o
);

  // 8 bits covers the full MEM_TMO range.
  localparam int              CNT_W    = 8;
  // The counter holds the number of mem_ready=0 cycles already spent in MEM;
  // when it sits at MEM_TMO-1 and mem_ready is still low, this cycle is the
  // MEM_TMO-th miss and the access is abandoned.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TMO - 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;

  logic is_rtype, is_imm, is_load, is_store;
  logic is_branch, is_call, is_ret, is_illegal;

  // Only the opcode field of the instruction is used by the control unit.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[INSTR_W-OPCODE_W-1:0];

  kgp_opcode_class #(
    .OPCODE_W (OPCODE_W)
  ) u_opcode_class (
    .opcode_i     (opcode_q),
    .is_rtype_o   (is_rtype),
    .is_imm_o     (is_imm),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_branch_o  (is_branch),
    .is_call_o    (is_call),
    .is_ret_o     (is_ret),
    .is_illegal_o (is_illegal)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    wait_cnt_d = '0;          // cleared whenever we are not waiting in MEM
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        opcode_d = instr[INSTR_W-1 -: OPCODE_W];
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        if (is_illegal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_rtype || is_imm) begin
          state_d = S_WB;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          // Branch, call and ret finish here: instruction boundary.
          state_d = start ? S_FETCH : S_IDLE;
        end
      end

      S_MEM: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (mem_ready) begin
          if (is_load) state_d = S_WB;
          else         state_d = start ? S_FETCH : S_IDLE;
        end else if (wait_cnt_q == TMO_LAST) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        state_d = start ? S_FETCH : S_IDLE;
      end

      S_TRAP: begin
        state_d = S_TRAP;     // only rst leaves TRAP
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs: registered state and latched opcode only
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    Branch      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUop       = ALUOP_W'(ALUOP_ADD);
    ALUsrc      = 1'b0;
    RegWrite    = 1'b0;
    ra_RegWrite = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end

      S_EXEC: begin
        if (is_rtype) begin
          ALUop = ALUOP_W'(ALUOP_FUNCT);
        end else if (is_imm) begin
          ALUop  = ALUOP_W'(ALUOP_IMM);
          ALUsrc = 1'b1;
        end else if (is_load || is_store) begin
          ALUop  = ALUOP_W'(ALUOP_ADD);
          ALUsrc = 1'b1;
        end else if (is_branch || is_ret || is_call) begin
          Branch      = 1'b1;
          pc_write    = 1'b1;
          ra_RegWrite = is_call;
        end
      end

      S_MEM: begin
        // Address stays on the bus for the whole access.
        ALUop    = ALUOP_W'(ALUOP_ADD);
        ALUsrc   = 1'b1;
        MemRead  = is_load;
        MemWrite = is_store;
      end

      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = is_load;
      end

      default: ;
    endcase
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

endmodule : kgp_multicycle_ctrl

// File: tb/tb_kgp_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kgp_multicycle_ctrl
//   Directed cycle-by-cycle stimulus. For each cycle the stimulus process
//   pushes the hand-written expected output vector onto a scoreboard queue;
//   an independent monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_kgp_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic        mem_ready;
  logic        ir_write, pc_write, Branch, MemRead, MemWrite, MemtoReg;
  logic [1:0]  ALUop;
  logic        ALUsrc, RegWrite, ra_RegWrite, busy, illegal_op, mem_timeout;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  kgp_multicycle_ctrl #(
    .INSTR_W  (32),
    .OPCODE_W (6),
    .ALUOP_W  (2),
    .MEM_TMO  (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instr       (instr),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .ALUop       (ALUop),
    .ALUsrc      (ALUsrc),
    .RegWrite    (RegWrite),
    .ra_RegWrite (ra_RegWrite),
    .busy        (busy),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       ra_reg_write;
    logic       busy;
    logic       illegal_op;
    logic       mem_timeout;
  } out_t;

  typedef struct {
    out_t  exp;
    string tag;
  } sb_entry_t;

  // Hand-written expected output vectors per state / instruction class.
  localparam out_t E_IDLE    = '{default: '0};
  localparam out_t E_FETCH   = '{default: '0, state: 3'd1, ir_write: 1'b1, pc_write: 1'b1, busy: 1'b1};
  localparam out_t E_DEC     = '{default: '0, state: 3'd2, busy: 1'b1};
  localparam out_t E_EX_R    = '{default: '0, state: 3'd3, alu_op: 2'b01, busy: 1'b1};
  localparam out_t E_EX_I    = '{default: '0, state: 3'd3, alu_op: 2'b10, alu_src: 1'b1, busy: 1'b1};
  localparam out_t E_EX_LS   = '{default: '0, state: 3'd3, alu_op: 2'b00, alu_src: 1'b1, busy: 1'b1};
  localparam out_t E_EX_BR   = '{default: '0, state: 3'd3, branch: 1'b1, pc_write: 1'b1, busy: 1'b1};
  localparam out_t E_EX_CALL = '{default: '0, state: 3'd3, branch: 1'b1, pc_write: 1'b1, ra_reg_write: 1'b1, busy: 1'b1};
  localparam out_t E_MEM_LW  = '{default: '0, state: 3'd4, mem_read: 1'b1, alu_src: 1'b1, busy: 1'b1};
  localparam out_t E_MEM_SW  = '{default: '0, state: 3'd4, mem_write: 1'b1, alu_src: 1'b1, busy: 1'b1};
  localparam out_t E_WB_R    = '{default: '0, state: 3'd5, reg_write: 1'b1, busy: 1'b1};
  localparam out_t E_WB_LW   = '{default: '0, state: 3'd5, reg_write: 1'b1, mem_to_reg: 1'b1, busy: 1'b1};
  localparam out_t E_TRAP_T  = '{default: '0, state: 3'd6, mem_timeout: 1'b1};
  localparam out_t E_TRAP_I  = '{default: '0, state: 3'd6, illegal_op: 1'b1};

  sb_entry_t sb_q[$];
  int        checks   = 0;
  int        failures = 0;

  out_t act;
  always_comb begin
    act = '{state: state_o, ir_write: ir_write, pc_write: pc_write,
            branch: Branch, mem_read: MemRead, mem_write: MemWrite,
            mem_to_reg: MemtoReg, alu_op: ALUop, alu_src: ALUsrc,
            reg_write: RegWrite, ra_reg_write: ra_RegWrite, busy: busy,
            illegal_op: illegal_op, mem_timeout: mem_timeout};
  end

  // Monitor: one expected vector per observed cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got state=%0d vec=%b, expected state=%0d vec=%b",
                 e.tag, act.state, act, e.exp.state, e.exp);
      end
    end
  end

  // One clock cycle of stimulus: drive inputs, queue the outputs expected
  // during this cycle, advance to just after the next rising edge.
  task automatic cyc(input out_t e, input logic st, input logic mr, input string tag);
    start     = st;
    mem_ready = mr;
    sb_q.push_back('{exp: e, tag: tag});
    @(posedge clk);
    #1;
  endtask

  // FETCH cycle with the given opcode on the instruction bus.
  task automatic fetch(input logic [5:0] op, input string tag);
    instr = {op, 26'h2A55A5A};
    cyc(E_FETCH, 1'b1, 1'b0, tag);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b0;
    instr     = '0;
    @(posedge clk);
    #1;
    cyc(E_IDLE, 1'b1, 1'b0, "in_reset");
    rst = 1'b0;
    cyc(E_IDLE, 1'b1, 1'b0, "idle_start");

    // R-type: 1,2,3,5 then back to FETCH.
    fetch(6'b000000, "r_fetch");
    cyc(E_DEC,  1'b1, 1'b0, "r_decode");
    cyc(E_EX_R, 1'b1, 1'b0, "r_exec");
    cyc(E_WB_R, 1'b1, 1'b0, "r_wb");

    // addi / compi
    fetch(6'b000100, "addi_fetch");
    cyc(E_DEC,  1'b1, 1'b0, "addi_decode");
    cyc(E_EX_I, 1'b1, 1'b0, "addi_exec");
    cyc(E_WB_R, 1'b1, 1'b0, "addi_wb");
    fetch(6'b000101, "compi_fetch");
    cyc(E_DEC,  1'b1, 1'b0, "compi_decode");
    cyc(E_EX_I, 1'b1, 1'b0, "compi_exec");
    cyc(E_WB_R, 1'b1, 1'b0, "compi_wb");

    // lw with 3 wait cycles: MemRead for 4 cycles, 8 cycles total.
    fetch(6'b000010, "lw3_fetch");
    cyc(E_DEC,   1'b1, 1'b0, "lw3_decode");
    cyc(E_EX_LS, 1'b1, 1'b0, "lw3_exec");
    for (int i = 0; i < 3; i++) cyc(E_MEM_LW, 1'b1, 1'b0, "lw3_mem_wait");
    cyc(E_MEM_LW, 1'b1, 1'b1, "lw3_mem_done");
    cyc(E_WB_LW,  1'b1, 1'b0, "lw3_wb");

    // lw with mem_ready already high.
    fetch(6'b000010, "lw0_fetch");
    cyc(E_DEC,    1'b1, 1'b0, "lw0_decode");
    cyc(E_EX_LS,  1'b1, 1'b0, "lw0_exec");
    cyc(E_MEM_LW, 1'b1, 1'b1, "lw0_mem");
    cyc(E_WB_LW,  1'b1, 1'b0, "lw0_wb");

    // sw with one wait cycle, straight back to FETCH.
    fetch(6'b000011, "sw1_fetch");
    cyc(E_DEC,    1'b1, 1'b0, "sw1_decode");
    cyc(E_EX_LS,  1'b1, 1'b0, "sw1_exec");
    cyc(E_MEM_SW, 1'b1, 1'b0, "sw1_mem_wait");
    cyc(E_MEM_SW, 1'b1, 1'b1, "sw1_mem_done");

    // Branch range edges and ret: 3 cycles each.
    fetch(6'b010000, "br_lo_fetch");
    cyc(E_DEC,   1'b1, 1'b0, "br_lo_decode");
    cyc(E_EX_BR, 1'b1, 1'b0, "br_lo_exec");
    fetch(6'b011001, "br_hi_fetch");
    cyc(E_DEC,   1'b1, 1'b0, "br_hi_decode");
    cyc(E_EX_BR, 1'b1, 1'b0, "br_hi_exec");
    fetch(6'b000111, "ret_fetch");
    cyc(E_DEC,   1'b1, 1'b0, "ret_decode");
    cyc(E_EX_BR, 1'b1, 1'b0, "ret_exec");

    // call with start dropped in EXEC: completes, then IDLE, no new fetch.
    fetch(6'b000110, "call_fetch");
    cyc(E_DEC,     1'b1, 1'b0, "call_decode");
    cyc(E_EX_CALL, 1'b0, 1'b0, "call_exec");
    cyc(E_IDLE,    1'b0, 1'b0, "call_idle0");
    cyc(E_IDLE,    1'b0, 1'b0, "call_idle1");
    cyc(E_IDLE,    1'b1, 1'b0, "restart");

    // sw completing with start low returns to IDLE.
    fetch(6'b000011, "sw0_fetch");
    cyc(E_DEC,    1'b1, 1'b0, "sw0_decode");
    cyc(E_EX_LS,  1'b1, 1'b0, "sw0_exec");
    cyc(E_MEM_SW, 1'b0, 1'b1, "sw0_mem");
    cyc(E_IDLE,   1'b1, 1'b0, "sw0_idle");

    // sw with mem_ready never high: 15 MEM cycles, then sticky TRAP.
    fetch(6'b000011, "swt_fetch");
    cyc(E_DEC,   1'b1, 1'b0, "swt_decode");
    cyc(E_EX_LS, 1'b1, 1'b0, "swt_exec");
    for (int i = 0; i < 15; i++) cyc(E_MEM_SW, 1'b1, 1'b0, "swt_mem");
    for (int i = 0; i < 3; i++)  cyc(E_TRAP_T, 1'b1, 1'b1, "swt_trap");

    rst = 1'b1;
    cyc(E_IDLE, 1'b1, 1'b0, "trap_reset");
    rst = 1'b0;
    cyc(E_IDLE, 1'b1, 1'b0, "idle_after_trap");

    // lw: mem_ready arrives on the cycle that would otherwise time out.
    fetch(6'b000010, "lwb_fetch");
    cyc(E_DEC,   1'b1, 1'b0, "lwb_decode");
    cyc(E_EX_LS, 1'b1, 1'b0, "lwb_exec");
    for (int i = 0; i < 14; i++) cyc(E_MEM_LW, 1'b1, 1'b0, "lwb_mem_wait");
    cyc(E_MEM_LW, 1'b1, 1'b1, "lwb_mem_boundary");
    cyc(E_WB_LW,  1'b0, 1'b0, "lwb_wb_stop");
    cyc(E_IDLE,   1'b1, 1'b0, "lwb_idle");

    // Asynchronous reset mid-MEM while MemRead is high.
    fetch(6'b000010, "lwr_fetch");
    cyc(E_DEC,    1'b1, 1'b0, "lwr_decode");
    cyc(E_EX_LS,  1'b1, 1'b0, "lwr_exec");
    cyc(E_MEM_LW, 1'b1, 1'b0, "lwr_mem");
    rst = 1'b1;
    cyc(E_IDLE, 1'b1, 1'b0, "rst_async_mid_mem");
    rst = 1'b0;
    cyc(E_IDLE, 1'b1, 1'b0, "idle_after_async_rst");

    // Opcode just past the branch range is illegal.
    fetch(6'b011010, "ill1_fetch");
    cyc(E_DEC, 1'b1, 1'b0, "ill1_decode");
    for (int i = 0; i < 2; i++) cyc(E_TRAP_I, 1'b1, 1'b0, "ill1_trap");

    rst = 1'b1;
    cyc(E_IDLE, 1'b1, 1'b0, "ill_reset");
    rst = 1'b0;
    cyc(E_IDLE, 1'b1, 1'b0, "idle_before_ill2");

    // Opcode 111111 traps with no strobe pulse.
    fetch(6'b111111, "ill2_fetch");
    cyc(E_DEC, 1'b1, 1'b0, "ill2_decode");
    for (int i = 0; i < 3; i++) cyc(E_TRAP_I, 1'b1, 1'b1, "ill2_trap");

    // Let the monitor drain whatever is still queued.
    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_kgp_multicycle_ctrl
